// File: rtl/key_strobe_conditioner_if.sv
// Push-button conditioner signal bundle.
// Ports:
//   key_raw     - raw, possibly bouncing button pin (toward the conditioner)
//   enable      - periodic one-cycle step strobe
//   a           - pending-press flag, held until consumed by a strobe
//   press_pulse - one-cycle pulse per accepted press
//   key_level   - debounced level, 1 = pressed
//   overrun     - one-cycle pulse when a press merges into a pending one
// master: the side that owns the button pin and consumes the strobes.
// slave:  the conditioner itself.
interface key_strobe_conditioner_if;
    logic key_raw;
    logic enable;
    logic a;
    logic press_pulse;
    logic key_level;
    logic overrun;

    modport master (
        output key_raw,
        input  enable, a, press_pulse, key_level, overrun
    );

    modport slave (
        input  key_raw,
        output enable, a, press_pulse, key_level, overrun
    );
endinterface

// File: rtl/key_strobe_conditioner.sv
// Front-end for the lab Moore FSM: synchronizes and debounces a push-button,
// turns each accepted press into a pending flag `a`, and generates the
// free-running `enable` step strobe that consumes that flag.
// Ports:
//   clock   - rising-edge system clock
//   reset_n - asynchronous, active-low reset
//   key_if  - slave modport: key_raw in; enable, a, press_pulse,
//             key_level, overrun out
//
// Debounce FSM states:
//   state        | meaning
//   IDLE         | released, waiting for a pressed sample
//   PRESS_WAIT   | counting consecutive pressed samples
//   PRESSED      | press accepted, waiting for a released sample
//   RELEASE_WAIT | counting consecutive released samples
module key_strobe_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int STROBE_DIV      = 25000000,
    parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic                      clock,
    input  logic                      reset_n,
    key_strobe_conditioner_if.slave   key_if
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int DIV_W = (STROBE_DIV > 1) ? $clog2(STROBE_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STROBE_DIV - 1);
    // Raw pin level that means "released".
    localparam logic KEY_RELEASED = KEY_ACTIVE_LOW;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } deb_state_t;

    logic             s1;
    logic             s2;
    logic             key_on;
    deb_state_t       state;
    deb_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             press_event;
    logic             level_next;
    logic [DIV_W-1:0] div_cnt;
    logic             enable_r;
    logic             a_r;
    logic             press_pulse_r;
    logic             key_level_r;
    logic             overrun_r;

    // Two-flop synchronizer; resets to the released pin level so a button
    // held through reset is seen as a fresh press afterwards.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= KEY_RELEASED;
            s2 <= KEY_RELEASED;
        end else begin
            s1 <= key_if.key_raw;
            s2 <= s1;
        end
    end

    // Normalized: 1 = pressed regardless of pin polarity.
    assign key_on = s2 ^ KEY_ACTIVE_LOW;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        press_event = 1'b0;
        case (state)
            IDLE: begin
                if (key_on) begin
                    state_next = PRESS_WAIT;
                    cnt_next   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!key_on) begin
                    state_next = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_next  = PRESSED;
                    press_event = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!key_on) begin
                    state_next = RELEASE_WAIT;
                    cnt_next   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (key_on) begin
                    state_next = PRESSED;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Registering from the next state makes key_level rise on the same edge
    // as press_pulse instead of one cycle later.
    assign level_next = (state_next == PRESSED) || (state_next == RELEASE_WAIT);

    // Free-running step strobe, independent of key activity.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt  <= '0;
            enable_r <= 1'b0;
        end else begin
            enable_r <= (div_cnt == DIV_LAST);
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

    // `a` survives the enable cycle (the FSM samples it there) and clears on
    // the edge that ends it, unless a new press lands on that same edge.
    // A press while one is still pending is merged and flagged as overrun.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_r           <= 1'b0;
            press_pulse_r <= 1'b0;
            key_level_r   <= 1'b0;
            overrun_r     <= 1'b0;
        end else begin
            a_r           <= press_event | (a_r & ~enable_r);
            press_pulse_r <= press_event;
            key_level_r   <= level_next;
            overrun_r     <= press_event & a_r & ~enable_r;
        end
    end

    assign key_if.enable      = enable_r;
    assign key_if.a           = a_r;
    assign key_if.press_pulse = press_pulse_r;
    assign key_if.key_level   = key_level_r;
    assign key_if.overrun     = overrun_r;

endmodule

// File: tb/tb_key_strobe_conditioner.sv
// Bench for key_strobe_conditioner. Two instances share one "pressed"
// stimulus: dut0 (active-low pin, strobe period 8) and dut1 (active-high
// pin, strobe period 32, long enough for two presses between strobes).
// A run-length reference model predicts each cycle's outputs into a
// scoreboard queue; a monitor pops and compares on the falling edge.
module tb_key_strobe_conditioner;

    localparam int DEB  = 4;
    localparam int DIV0 = 8;
    localparam int DIV1 = 32;

    typedef logic [4:0] vec_t; // {enable, a, press_pulse, key_level, overrun}

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic pressed = 1'b0;

    always #5 clock = ~clock;

    key_strobe_conditioner_if if0 ();
    key_strobe_conditioner_if if1 ();

    assign if0.key_raw = ~pressed;
    assign if1.key_raw = pressed;

    key_strobe_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .STROBE_DIV      (DIV0),
        .KEY_ACTIVE_LOW  (1'b1)
    ) u_dut0 (
        .clock   (clock),
        .reset_n (reset_n),
        .key_if  (if0.slave)
    );

    key_strobe_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .STROBE_DIV      (DIV1),
        .KEY_ACTIVE_LOW  (1'b0)
    ) u_dut1 (
        .clock   (clock),
        .reset_n (reset_n),
        .key_if  (if1.slave)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    vec_t sb0[$];
    vec_t sb1[$];

    // Reference model state, per instance.
    int n_edge[2];
    bit p1[2];
    bit p2[2];
    bit level[2];
    int run[2];
    bit a_m[2];
    bit en_prev[2];

    task automatic check_vec(input string nm, input vec_t got, input vec_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: {en,a,pp,lvl,ovr} got %b expected %b", nm, cyc, got, exp);
        end
    endtask

    task automatic check_bit(input string nm, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", nm, got, exp);
        end
    endtask

    // Model: the key level seen by the debouncer is the pin sampled two
    // edges earlier; a level change is accepted once DEB+1 consecutive
    // samples disagree with the current accepted level.
    initial begin
        forever begin
            @(posedge clock);
            cyc++;
            for (int i = 0; i < 2; i++) begin
                vec_t e;
                bit   smp;
                bit   ev;
                bit   en;
                bit   a_new;
                int   div;
                if (!reset_n) begin
                    n_edge[i]  = 0;
                    p1[i]      = 1'b0;
                    p2[i]      = 1'b0;
                    level[i]   = 1'b0;
                    run[i]     = 0;
                    a_m[i]     = 1'b0;
                    en_prev[i] = 1'b0;
                    e          = '0;
                end else begin
                    div = (i == 0) ? DIV0 : DIV1;
                    n_edge[i]++;
                    smp   = p2[i];
                    p2[i] = p1[i];
                    p1[i] = pressed;
                    if (smp != level[i]) run[i]++;
                    else run[i] = 0;
                    ev = 1'b0;
                    if (run[i] == DEB + 1) begin
                        level[i] = smp;
                        run[i]   = 0;
                        ev       = smp;
                    end
                    en    = ((n_edge[i] % div) == 0);
                    a_new = ev | (a_m[i] & ~en_prev[i]);
                    e     = {en, a_new, ev, level[i], ev & a_m[i] & ~en_prev[i]};
                    a_m[i]     = a_new;
                    en_prev[i] = en;
                end
                if (i == 0) sb0.push_back(e);
                else sb1.push_back(e);
            end
        end
    end

    // Monitor: every cycle the DUTs present a full output vector.
    initial begin
        forever begin
            @(negedge clock);
            if (sb0.size() > 0) begin
                vec_t x0;
                x0 = sb0.pop_front();
                check_vec("dut0 outputs", {if0.enable, if0.a, if0.press_pulse, if0.key_level, if0.overrun}, x0);
            end
            if (sb1.size() > 0) begin
                vec_t x1;
                x1 = sb1.pop_front();
                check_vec("dut1 outputs", {if1.enable, if1.a, if1.press_pulse, if1.key_level, if1.overrun}, x1);
            end
        end
    end

    task automatic hold(input bit lvl, input int cycles);
        pressed = lvl;
        repeat (cycles) begin
            @(posedge clock);
            #2;
        end
    endtask

    // Wait until instance i has just taken an edge with n % div == r.
    task automatic align_to(input int i, input int r);
        int div;
        div = (i == 0) ? DIV0 : DIV1;
        for (int k = 0; k < 2 * div; k++) begin
            @(posedge clock);
            #2;
            if ((n_edge[i] % div) == r) break;
        end
    endtask

    initial begin
        // Reset held while the pin toggles.
        for (int k = 0; k < 10; k++) begin
            @(posedge clock);
            #2 pressed = ~pressed;
        end
        pressed = 1'b0;
        @(negedge clock);
        #2 reset_n = 1'b1;

        hold(1'b0, 20);
        // Clean press and release.
        hold(1'b1, 20);
        hold(1'b0, 14);
        // Press bounce: short presses rejected, then stable.
        hold(1'b1, 2);
        hold(1'b0, 3);
        hold(1'b1, 3);
        hold(1'b0, 3);
        hold(1'b1, 14);
        // Release bounce while held, then stable release.
        hold(1'b0, 1);
        hold(1'b1, 6);
        hold(1'b0, 1);
        hold(1'b1, 6);
        hold(1'b0, 14);
        // Two presses inside one dut1 strobe window -> overrun.
        align_to(1, 1);
        hold(1'b1, 7);
        hold(1'b0, 7);
        hold(1'b1, 7);
        hold(1'b0, 14);
        // Press event landing on a dut0 enable cycle.
        align_to(0, 2);
        hold(1'b1, 12);
        hold(1'b0, 14);
        // Random bouncing.
        for (int k = 0; k < 60; k++) begin
            hold(1'($urandom_range(0, 1)), $urandom_range(1, 9));
        end
        hold(1'b0, 14);
        // Reset with dut1 a pending and its debouncer in PRESS_WAIT.
        align_to(1, 1);
        hold(1'b1, 8);
        hold(1'b0, 8);
        hold(1'b1, 3);
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check_bit("dut0 a in reset", if0.a, 1'b0);
        check_bit("dut0 key_level in reset", if0.key_level, 1'b0);
        check_bit("dut1 a in reset", if1.a, 1'b0);
        check_bit("dut1 key_level in reset", if1.key_level, 1'b0);
        repeat (3) @(negedge clock);
        #2 reset_n = 1'b1;
        // Key still held: accepted again after a full debounce.
        hold(1'b1, 12);
        hold(1'b0, 14);
        repeat (2) @(negedge clock);
        #1;
        n_cmp++;
        if (n_cmp < 500) begin
            n_bad++;
            $display("FAIL comparison count: got %0d expected at least 500", n_cmp);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
